// File: rtl/int_xing_pkg.sv
// Shared definitions for the interrupt clock-domain crossing blocks.
// Synchronizer depth limits and the default interrupt vector type live here.
package int_xing_pkg;

   localparam int INT_SYNC_MIN = 2;
   localparam int INT_SYNC_MAX = 4;
   localparam int INT_W        = 2;

   typedef logic [INT_W-1:0] int_vec_t;

   function automatic bit sync_depth_ok(input int depth);
      return (depth >= INT_SYNC_MIN) && (depth <= INT_SYNC_MAX);
   endfunction

endpackage

// File: rtl/int_sync_chain.sv
// Multi-bit flop-chain synchronizer, reset to 0; each bit resynchronized independently.
// Shared by the crossing sinks; stages are pure flop-to-flop with no logic between them.
module int_sync_chain
   import int_xing_pkg::*;
#(
   parameter int W    = INT_W,
   parameter int SYNC = 3
)
(
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (!sync_depth_ok(SYNC)) begin : g_bad_sync
      $error("int_sync_chain: SYNC=%0d outside %0d..%0d", SYNC, INT_SYNC_MIN, INT_SYNC_MAX);
   end

   // Mark the chain so tools keep it intact, place it tightly and never retime into it.
   (* ASYNC_REG = "TRUE", keep = "true", dont_touch = "true", shreg_extract = "no" *)
   logic [SYNC-1:0][W-1:0] stage_q;
   logic [SYNC-1:0][W-1:0] stage_d;

   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = d;
      for (int k = 1; k < SYNC; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[SYNC-1];

endmodule

// File: rtl/int_sync_crossing_sink.sv
// Receive side of the interrupt crossing: resynchronizes the remote interrupt vector,
// then provides levels, rising-edge pulses and sticky pending bits with a clear port.
module int_sync_crossing_sink
   import int_xing_pkg::*;
#(
   parameter int W       = INT_W,
   parameter int SYNC    = 3,
   parameter bit PEND_EN = 1'b1
)
(
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] auto_in_sync,
   output logic [W-1:0] auto_out,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] pend_o,
   input  logic         clr_valid,
   input  logic [W-1:0] clr_mask,
   output logic         clr_ready
);

   if ((W < 1) || (W > 64)) begin : g_bad_width
      $error("int_sync_crossing_sink: W=%0d outside 1..64", W);
   end

   logic [W-1:0] sync_level;
   logic [W-1:0] level_q;
   logic [W-1:0] level_d;

   int_sync_chain #(
      .W    (W),
      .SYNC (SYNC)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (auto_in_sync),
      .q     (sync_level)
   );

   always_comb begin
      level_d = sync_level;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign auto_out  = sync_level;
   assign rise_o    = sync_level & ~level_q;
   assign clr_ready = ~reset;

   if (PEND_EN) begin : g_pend
      logic [W-1:0] pend_q;
      logic [W-1:0] pend_d;
      logic         clr_fire;

      assign clr_fire = clr_valid & clr_ready;

      // A new edge always wins over a simultaneous clear so no interrupt is dropped.
      always_comb begin
         pend_d = pend_q;
         for (int i = 0; i < W; i++) begin
            if (rise_o[i]) begin
               pend_d[i] = 1'b1;
            end else if (clr_fire && clr_mask[i]) begin
               pend_d[i] = 1'b0;
            end
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            pend_q <= '0;
         end else begin
            pend_q <= pend_d;
         end
      end

      assign pend_o = pend_q;
   end else begin : g_no_pend
      logic unused_clr;
      assign unused_clr = ^{clr_valid, clr_mask};
      assign pend_o     = '0;
   end

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
// Directed scoreboard bench: stimulus rows push hand-computed expectations, a negedge monitor checks them.
module tb_int_sync_crossing_sink;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] auto_in_sync;
   logic       clr_valid;
   logic [1:0] clr_mask;

   logic [1:0] auto_out, rise_o, pend_o;
   logic       clr_ready;
   logic [1:0] aout2, rise2, pend2;
   logic       rdy2;
   logic       unused_tb;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      tag;
      logic [1:0] aout;
      logic [1:0] rise;
      logic [1:0] pend;
      logic       rdy;
      int         a2;
   } exp_t;

   exp_t exp_q[$];

   always #5 clock = ~clock;

   int_sync_crossing_sink #(.W(2), .SYNC(3), .PEND_EN(1'b1)) dut (
      .clock        (clock),
      .reset        (reset),
      .auto_in_sync (auto_in_sync),
      .auto_out     (auto_out),
      .rise_o       (rise_o),
      .pend_o       (pend_o),
      .clr_valid    (clr_valid),
      .clr_mask     (clr_mask),
      .clr_ready    (clr_ready)
   );

   int_sync_crossing_sink #(.W(2), .SYNC(2), .PEND_EN(1'b0)) dut2 (
      .clock        (clock),
      .reset        (reset),
      .auto_in_sync (auto_in_sync),
      .auto_out     (aout2),
      .rise_o       (rise2),
      .pend_o       (pend2),
      .clr_valid    (clr_valid),
      .clr_mask     (clr_mask),
      .clr_ready    (rdy2)
   );

   assign unused_tb = ^rise2;

   task automatic chk(input string tag, input string fld, input logic [1:0] got, input logic [1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s.%s got=%b want=%b @%0t", tag, fld, got, want, $time);
      end else begin
         $display("ok   %s.%s = %b", tag, fld, got);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.tag, "auto_out", auto_out, e.aout);
         chk(e.tag, "rise_o", rise_o, e.rise);
         chk(e.tag, "pend_o", pend_o, e.pend);
         chk(e.tag, "clr_ready", {1'b0, clr_ready}, {1'b0, e.rdy});
         chk(e.tag, "s2_pend_o", pend2, 2'b00);
         chk(e.tag, "s2_clr_ready", {1'b0, rdy2}, {1'b0, e.rdy});
         if (e.a2 >= 0) begin
            chk(e.tag, "s2_auto_out", aout2, e.a2[1:0]);
         end
      end
   end

   // One cycle: drive inputs, queue what must be seen before the next edge, advance.
   task automatic row(input string tag, input logic [1:0] in_v, input logic cv, input logic [1:0] cm,
                      input logic rst, input logic [1:0] ea, input logic [1:0] er, input logic [1:0] ep,
                      input logic erdy, input int ea2 = -1);
      exp_t e;
      auto_in_sync = in_v;
      clr_valid    = cv;
      clr_mask     = cm;
      reset        = rst;
      e.tag  = tag;
      e.aout = ea;
      e.rise = er;
      e.pend = ep;
      e.rdy  = erdy;
      e.a2   = ea2;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      auto_in_sync = 2'b00;
      clr_valid    = 1'b0;
      clr_mask     = 2'b00;
      @(posedge clock);
      #1;

      // reset and latency
      row("rst",  2'b00, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0);
      row("c0",   2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
      row("c1",   2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
      row("c2",   2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 1);
      row("c3",   2'b01, 0, 2'b00, 0, 2'b01, 2'b01, 2'b00, 1, 1);
      row("c4",   2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 1);
      row("c5",   2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 1);

      // clear while the level stays high
      row("clr",  2'b01, 1, 2'b01, 0, 2'b01, 2'b00, 2'b01, 1);
      for (int i = 0; i < 21; i++) begin
         row("held", 2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1);
      end

      // set and clear of bit 1 in the same cycle
      row("sc0",  2'b11, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1);
      row("sc1",  2'b11, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1);
      row("sc2",  2'b11, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1);
      row("sc3",  2'b11, 1, 2'b10, 0, 2'b11, 2'b10, 2'b00, 1);
      row("sc4",  2'b11, 0, 2'b00, 0, 2'b11, 2'b00, 2'b10, 1);

      // independent bits: 00 -> 11 -> 10 -> 11, with a clear of a non-pending bit
      row("d0",   2'b00, 0, 2'b00, 0, 2'b11, 2'b00, 2'b10, 1);
      row("d1",   2'b00, 1, 2'b01, 0, 2'b11, 2'b00, 2'b10, 1);
      row("d2",   2'b00, 0, 2'b00, 0, 2'b11, 2'b00, 2'b10, 1);
      row("d3",   2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1);
      row("d4",   2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1);
      row("e0",   2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1);
      row("e1",   2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1);
      row("e2",   2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1);
      row("e3",   2'b11, 0, 2'b00, 0, 2'b11, 2'b11, 2'b10, 1);
      row("e4",   2'b11, 0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 1);
      row("f0",   2'b10, 0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 1);
      row("f1",   2'b10, 0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 1);
      row("f2",   2'b10, 0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 1);
      row("f3",   2'b10, 0, 2'b00, 0, 2'b10, 2'b00, 2'b11, 1);
      row("f4",   2'b10, 0, 2'b00, 0, 2'b10, 2'b00, 2'b11, 1);
      row("g0",   2'b11, 0, 2'b00, 0, 2'b10, 2'b00, 2'b11, 1);
      row("g1",   2'b11, 0, 2'b00, 0, 2'b10, 2'b00, 2'b11, 1);
      row("g2",   2'b11, 0, 2'b00, 0, 2'b10, 2'b00, 2'b11, 1);
      row("g3",   2'b11, 0, 2'b00, 0, 2'b11, 2'b01, 2'b11, 1);
      row("g4",   2'b11, 0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 1);

      // reset mid-operation with inputs held high
      row("mrst", 2'b11, 0, 2'b00, 1, 2'b11, 2'b00, 2'b11, 0);
      row("r0",   2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
      row("r1",   2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
      row("r2",   2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 3);
      row("r3",   2'b11, 0, 2'b00, 0, 2'b11, 2'b11, 2'b00, 1, 3);
      row("r4",   2'b11, 0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 1, 3);

      repeat (2) @(posedge clock);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
